dma_cmd_sched: RTL



---
 rtl/dma_cmd_sched.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_cmd_sched.sv
// dma_cmd_sched: round-robin scheduler for DMA commands.
// Each grant becomes four config writes, a done wait and a status.
module dma_cmd_sched #(
  parameter int          NREQ      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [3:0]  AXI_ID    = 4'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ*96-1:0] req_msg,
  input  logic [NREQ-1:0]    req_val,
  output logic [NREQ-1:0]    req_rdy,
  output logic [1:0]         rsp_msg,
  output logic [NREQ-1:0]    rsp_val,
  input  logic [NREQ-1:0]    rsp_rdy,
  output logic [43:0]        cfg_aw_msg,
  output logic               cfg_aw_val,
  input  logic               cfg_aw_rdy,
  output logic [72:0]        cfg_w_msg,
  output logic               cfg_w_val,
  input  logic               cfg_w_rdy,
  input  logic [5:0]         cfg_b_msg,
  input  logic               cfg_b_val,
  output logic               cfg_b_rdy,
  input  logic               done_msg,
  input  logic               done_val,
  output logic               done_rdy,
  output logic               busy,
  output logic [2:0]         owner
);

  typedef enum logic [2:0] {
    IDLE, GRANT, CFG, WAIT_B, WAIT_DONE, RSP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      reg_idx_q, reg_idx_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [31:0]     len_q, len_d;
  logic [NREQ-1:0] req_rdy_q, req_rdy_d;
  logic [NREQ-1:0] rsp_val_q, rsp_val_d;
  logic [1:0]      rsp_msg_q, rsp_msg_d;
  logic [43:0]     aw_msg_q, aw_msg_d;
  logic            aw_val_q, aw_val_d;
  logic [72:0]     w_msg_q, w_msg_d;
  logic            w_val_q, w_val_d;
  logic            b_rdy_q, b_rdy_d;
  logic            done_rdy_q, done_rdy_d;
  logic            busy_q, busy_d;
  logic [2:0]      owner_q, owner_d;

  logic [2*NREQ-1:0] dbl;
  logic [2:0]        winner;
  logic              found;
  int                win_idx;
  logic [95:0]       sel_msg;
  logic              aw_ok, w_ok;
  logic              b_id_unused;

  // The B id is not checked; only resp matters.
  assign b_id_unused = ^cfg_b_msg[5:2];

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [43:0] aw_word(input logic [1:0] idx);
    return {AXI_ID, BASE_ADDR + {27'd0, idx, 3'd0}, 8'd0};
  endfunction

  function automatic logic [72:0] w_word(
    input logic [1:0]  idx,
    input logic [31:0] s,
    input logic [31:0] d,
    input logic [31:0] l
  );
    logic [31:0] v;
    case (idx)
      2'd0:    v = s;
      2'd1:    v = d;
      2'd2:    v = l;
      default: v = 32'd1;
    endcase
    return {32'd0, v, 8'hFF, 1'b1};
  endfunction

  // Arbiter: first requester at or after rr_ptr, with wrap.
  always_comb begin
    dbl     = {req_val, req_val} >> rr_ptr_q;
    found   = 1'b0;
    win_idx = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (dbl[j]) begin
        found   = 1'b1;
        win_idx = int'(rr_ptr_q) + j;
      end
    end
    if (win_idx >= NREQ) win_idx = win_idx - NREQ;
    winner = 3'(win_idx);
  end

  // Command fields of the requester being granted.
  always_comb begin
    sel_msg = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) sel_msg = req_msg[i*96 +: 96];
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    reg_idx_d  = reg_idx_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    req_rdy_d  = req_rdy_q;
    rsp_val_d  = rsp_val_q;
    rsp_msg_d  = rsp_msg_q;
    aw_msg_d   = aw_msg_q;
    aw_val_d   = aw_val_q;
    w_msg_d    = w_msg_q;
    w_val_d    = w_val_q;
    b_rdy_d    = b_rdy_q;
    done_rdy_d = done_rdy_q;
    owner_d    = owner_q;
    aw_ok      = !aw_val_q || cfg_aw_rdy;
    w_ok       = !w_val_q || cfg_w_rdy;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = GRANT;
          owner_d   = winner;
          req_rdy_d = onehot(winner);
        end
      end
      GRANT: begin
        req_rdy_d = '0;
        src_d     = sel_msg[31:0];
        dst_d     = sel_msg[63:32];
        len_d     = sel_msg[95:64];
        reg_idx_d = 2'd0;
        if (sel_msg[95:64] == 32'd0) begin
          state_d   = RSP;
          rsp_val_d = onehot(owner_q);
          rsp_msg_d = 2'b10;
        end else begin
          state_d  = CFG;
          aw_val_d = 1'b1;
          w_val_d  = 1'b1;
          aw_msg_d = aw_word(2'd0);
          w_msg_d  = w_word(2'd0, sel_msg[31:0],
                            sel_msg[63:32], sel_msg[95:64]);
        end
      end
      CFG: begin
        if (cfg_aw_rdy) aw_val_d = 1'b0;
        if (cfg_w_rdy) w_val_d = 1'b0;
        if (aw_ok && w_ok) begin
          state_d = WAIT_B;
          b_rdy_d = 1'b1;
        end
      end
      WAIT_B: begin
        if (cfg_b_val && b_rdy_q) begin
          b_rdy_d = 1'b0;
          if (cfg_b_msg[1:0] != 2'b00) begin
            state_d   = RSP;
            rsp_val_d = onehot(owner_q);
            rsp_msg_d = 2'b11;
          end else if (reg_idx_q != 2'd3) begin
            state_d   = CFG;
            reg_idx_d = reg_idx_q + 2'd1;
            aw_val_d  = 1'b1;
            w_val_d   = 1'b1;
            aw_msg_d  = aw_word(reg_idx_q + 2'd1);
            w_msg_d   = w_word(reg_idx_q + 2'd1,
                               src_q, dst_q, len_q);
          end else begin
            state_d    = WAIT_DONE;
            done_rdy_d = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (done_val && done_rdy_q) begin
          done_rdy_d = 1'b0;
          state_d    = RSP;
          rsp_val_d  = onehot(owner_q);
          rsp_msg_d  = done_msg ? 2'b00 : 2'b01;
        end
      end
      RSP: begin
        if (|(rsp_val_q & rsp_rdy)) begin
          rsp_val_d = '0;
          state_d   = IDLE;
          rr_ptr_d  = (int'(owner_q) == NREQ - 1) ?
                      3'd0 : owner_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 3'd0;
      reg_idx_q  <= 2'd0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      req_rdy_q  <= '0;
      rsp_val_q  <= '0;
      rsp_msg_q  <= 2'b00;
      aw_msg_q   <= '0;
      aw_val_q   <= 1'b0;
      w_msg_q    <= '0;
      w_val_q    <= 1'b0;
      b_rdy_q    <= 1'b0;
      done_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
      owner_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      reg_idx_q  <= reg_idx_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      req_rdy_q  <= req_rdy_d;
      rsp_val_q  <= rsp_val_d;
      rsp_msg_q  <= rsp_msg_d;
      aw_msg_q   <= aw_msg_d;
      aw_val_q   <= aw_val_d;
      w_msg_q    <= w_msg_d;
      w_val_q    <= w_val_d;
      b_rdy_q    <= b_rdy_d;
      done_rdy_q <= done_rdy_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
    end
  end

  assign req_rdy    = req_rdy_q;
  assign rsp_val    = rsp_val_q;
  assign rsp_msg    = rsp_msg_q;
  assign cfg_aw_msg = aw_msg_q;
  assign cfg_aw_val = aw_val_q;
  assign cfg_w_msg  = w_msg_q;
  assign cfg_w_val  = w_val_q;
  assign cfg_b_rdy  = b_rdy_q;
  assign done_rdy   = done_rdy_q;
  assign busy       = busy_q;
  assign owner      = owner_q;

endmodule
